// File: rtl/zstd_pkg.sv
// Shared zstd block-layer types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package zstd_pkg;

  typedef enum logic [1:0] {
    RAW        = 2'd0,
    RLE        = 2'd1,
    COMPRESSED = 2'd2,
    RESERVED   = 2'd3
  } block_type_t;

  // Largest legal block payload in bytes.
  localparam int unsigned MAX_BLOCK_SIZE  = 131072;
  // Block header length in bytes (little-endian 24-bit word).
  localparam int unsigned BLOCK_HDR_BYTES = 3;

endpackage

// File: rtl/byte_unpacker.sv
// Splits 16-bit input words into a byte stream through a 2-byte holding register.
// Latency: an accepted byte is visible at byte_dat the cycle after acceptance.
// Backpressure: in_ready only while the register is empty and accept_en is high; pop drains one byte.
module byte_unpacker
  import zstd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept_en,
  input  logic [15:0] data_in,
  input  logic [1:0]  in_keep,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        pop,
  output logic        byte_vld,
  output logic [7:0]  byte_dat
);

  logic [7:0] b0_q, b0_d;
  logic [7:0] b1_q, b1_d;
  logic [1:0] cnt_q, cnt_d;

  assign in_ready = accept_en && (cnt_q == 2'd0);
  assign byte_vld = (cnt_q != 2'd0);
  assign byte_dat = b0_q;

  // Load a word (keep-qualified) when empty, otherwise shift out the oldest byte on pop.
  always_comb begin
    b0_d  = b0_q;
    b1_d  = b1_q;
    cnt_d = cnt_q;
    if (clear) begin
      b0_d  = 8'd0;
      b1_d  = 8'd0;
      cnt_d = 2'd0;
    end else if (in_valid && in_ready) begin
      // keep = 00 is accepted and dropped; the high byte only counts alongside the low one.
      if (in_keep[0]) begin
        b0_d  = data_in[7:0];
        b1_d  = in_keep[1] ? data_in[15:8] : 8'd0;
        cnt_d = in_keep[1] ? 2'd2 : 2'd1;
      end
    end else if (pop && byte_vld) begin
      b0_d  = b1_q;
      b1_d  = 8'd0;
      cnt_d = cnt_q - 2'd1;
    end
  end

  // Holding register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      b0_q  <= 8'd0;
      b1_q  <= 8'd0;
      cnt_q <= 2'd0;
    end else begin
      b0_q  <= b0_d;
      b1_q  <= b1_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/block_header_parser.sv
// Parses zstd block headers and forwards raw/compressed payload or expands RLE blocks.
// Latency: header fields pulse one cycle after the third header byte; payload one byte per cycle.
// Backpressure: out_ready low stalls byte consumption; in_ready drops while the holding register is occupied.
module block_header_parser
  import zstd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] data_in,
  input  logic [1:0]  in_keep,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        last_block,
  output logic [1:0]  block_type,
  output logic [20:0] block_size,
  output logic        hdr_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_is_rle,
  output logic        finished,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, HDR, RAW, RLE_LOAD, RLE_EMIT, DONE, ERROR} state_t;

  localparam logic [20:0] MAX_SIZE = 21'(MAX_BLOCK_SIZE);
  localparam logic [1:0]  HDR_LAST = 2'(BLOCK_HDR_BYTES - 1);

  state_t      state_q, state_d;
  logic [1:0]  hcnt_q, hcnt_d;
  logic [15:0] hlo_q, hlo_d;
  logic [20:0] cnt_q, cnt_d;
  logic [7:0]  rle_q, rle_d;
  logic        last_q, last_d;
  logic [1:0]  type_q, type_d;
  logic [20:0] size_q, size_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        finished_q, finished_d;
  logic        error_q, error_d;

  logic        pop;
  logic        accept_en;
  logic        byte_vld;
  logic [7:0]  byte_dat;
  logic [23:0] hdr_full;
  block_type_t hdr_type;
  logic [20:0] hdr_size;
  logic        hdr_bad;
  logic        out_xfer;

  assign accept_en = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);

  byte_unpacker u_unpacker (
    .clk       (clk),
    .reset     (reset),
    .clear     (start),
    .accept_en (accept_en),
    .data_in   (data_in),
    .in_keep   (in_keep),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pop       (pop),
    .byte_vld  (byte_vld),
    .byte_dat  (byte_dat)
  );

  // The third header byte is decoded straight off the holding register.
  assign hdr_full = {byte_dat, hlo_q};
  assign hdr_type = block_type_t'(hdr_full[2:1]);
  assign hdr_size = hdr_full[23:3];
  assign hdr_bad  = (hdr_type == zstd_pkg::RESERVED) || (hdr_size > MAX_SIZE);
  assign out_xfer = out_valid && out_ready;

  // Next-state, header decode, payload counting and output drive.
  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    hlo_d       = hlo_q;
    cnt_d       = cnt_q;
    rle_d       = rle_q;
    last_d      = last_q;
    type_d      = type_q;
    size_d      = size_q;
    hdr_valid_d = 1'b0;
    finished_d  = finished_q || (state_q == DONE);
    error_d     = error_q;
    pop         = 1'b0;
    out_valid   = 1'b0;
    out_data    = 8'd0;
    out_is_rle  = 1'b0;

    case (state_q)
      HDR: begin
        if (byte_vld) begin
          pop = 1'b1;
          if (hcnt_q == HDR_LAST) begin
            hcnt_d      = 2'd0;
            hdr_valid_d = 1'b1;
            last_d      = hdr_full[0];
            type_d      = hdr_full[2:1];
            size_d      = hdr_size;
            cnt_d       = hdr_size;
            if (hdr_bad) begin
              state_d = ERROR;
              error_d = 1'b1;
            end else if (hdr_type == zstd_pkg::RLE) begin
              state_d = RLE_LOAD;
            end else if (hdr_size == 21'd0) begin
              state_d = hdr_full[0] ? DONE : HDR;
            end else begin
              state_d = RAW;
            end
          end else begin
            if (hcnt_q == 2'd0) hlo_d[7:0]  = byte_dat;
            else                hlo_d[15:8] = byte_dat;
            hcnt_d = hcnt_q + 2'd1;
          end
        end
      end
      RAW: begin
        out_valid = byte_vld;
        out_data  = byte_vld ? byte_dat : 8'd0;
        if (out_xfer) begin
          pop   = 1'b1;
          cnt_d = cnt_q - 21'd1;
          if (cnt_q == 21'd1) state_d = last_q ? DONE : HDR;
        end
      end
      RLE_LOAD: begin
        if (byte_vld) begin
          pop     = 1'b1;
          rle_d   = byte_dat;
          // A zero-length RLE block still swallows its one byte.
          if (cnt_q == 21'd0) state_d = last_q ? DONE : HDR;
          else                state_d = RLE_EMIT;
        end
      end
      RLE_EMIT: begin
        out_valid  = 1'b1;
        out_data   = rle_q;
        out_is_rle = 1'b1;
        if (out_xfer) begin
          cnt_d = cnt_q - 21'd1;
          if (cnt_q == 21'd1) state_d = last_q ? DONE : HDR;
        end
      end
      default: ;
    endcase

    // start restarts header parsing from any state, abandoning a block in flight.
    if (start) begin
      state_d     = HDR;
      hcnt_d      = 2'd0;
      cnt_d       = 21'd0;
      hdr_valid_d = 1'b0;
      finished_d  = 1'b0;
      error_d     = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hcnt_q      <= 2'd0;
      hlo_q       <= 16'd0;
      cnt_q       <= 21'd0;
      rle_q       <= 8'd0;
      last_q      <= 1'b0;
      type_q      <= 2'd0;
      size_q      <= 21'd0;
      hdr_valid_q <= 1'b0;
      finished_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      hlo_q       <= hlo_d;
      cnt_q       <= cnt_d;
      rle_q       <= rle_d;
      last_q      <= last_d;
      type_q      <= type_d;
      size_q      <= size_d;
      hdr_valid_q <= hdr_valid_d;
      finished_q  <= finished_d;
      error_q     <= error_d;
    end
  end

  assign last_block = last_q;
  assign block_type = type_q;
  assign block_size = size_q;
  assign hdr_valid  = hdr_valid_q;
  assign finished   = finished_q;
  assign error      = error_q;

endmodule

// File: tb/tb_block_header_parser.sv
// Directed scoreboard bench for block_header_parser.
// Latency: expectations are queued at stimulus time, popped by an independent monitor.
// Backpressure: out_ready is held high, randomised, or held low per test.
module tb_block_header_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] data_in;
  logic [1:0]  in_keep;
  logic        in_valid;
  logic        in_ready;
  logic        last_block;
  logic [1:0]  block_type;
  logic [20:0] block_size;
  logic        hdr_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_is_rle;
  logic        finished;
  logic        error;

  always #5 clk = ~clk;

  block_header_parser dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .in_keep    (in_keep),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .last_block (last_block),
    .block_type (block_type),
    .block_size (block_size),
    .hdr_valid  (hdr_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_is_rle (out_is_rle),
    .finished   (finished),
    .error      (error)
  );

  typedef struct packed {
    logic        last;
    logic [1:0]  typ;
    logic [20:0] size;
  } hdr_exp_t;

  typedef struct packed {
    logic [7:0] dat;
    logic       rle;
  } out_exp_t;

  hdr_exp_t hq[$];
  out_exp_t oq[$];
  int checks   = 0;
  int failures = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: held low

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops expectations whenever the DUT presents a header or transfers a byte.
  initial begin
    hdr_exp_t h;
    out_exp_t o;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (hdr_valid) begin
          if (hq.size() == 0) fail_now("hdr_unexpected");
          else begin
            h = hq.pop_front();
            check("hdr_last", 32'(last_block), 32'(h.last));
            check("hdr_type", 32'(block_type), 32'(h.typ));
            check("hdr_size", 32'(block_size), 32'(h.size));
          end
        end
        if (out_valid && out_ready) begin
          if (oq.size() == 0) fail_now("out_unexpected");
          else begin
            o = oq.pop_front();
            check("out_data", 32'(out_data), 32'(o.dat));
            check("out_is_rle", 32'(out_is_rle), 32'(o.rle));
          end
        end
      end
    end
  end

  // Downstream ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] k);
    bit done = 1'b0;
    data_in  = d;
    in_keep  = k;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    data_in  = 16'd0;
    in_keep  = 2'd0;
    if (!done) fail_now("send_timeout");
  endtask

  task automatic exp_hdr(input logic l, input logic [1:0] t, input logic [20:0] s);
    hq.push_back({l, t, s});
  endtask

  task automatic exp_byte(input logic [7:0] d, input logic r);
    oq.push_back({d, r});
  endtask

  // which = 0 waits for finished, 1 for error, 2 for out_valid.
  task automatic wait_flag(input string name, input int which, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      case (which)
        0:       ok = finished;
        1:       ok = error;
        default: ok = out_valid;
      endcase
    end
    check(name, 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drained(input string name);
    check({name, "_hdr_left"}, 32'(hq.size()), 32'd0);
    check({name, "_bytes_left"}, 32'(oq.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_in_ready"}, 32'(in_ready), 32'd0);
    check({name, "_hdr_valid"}, 32'(hdr_valid), 32'd0);
    check({name, "_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_finished"}, 32'(finished), 32'd0);
    check({name, "_error"}, 32'(error), 32'd0);
    check({name, "_fields"}, 32'({last_block, block_type, block_size}), 32'd0);
    check({name, "_out_data"}, 32'({out_is_rle, out_data}), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    data_in  = 16'd0;
    in_keep  = 2'd0;
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_idle_outputs("reset");
    tick();
    reset = 1'b0;
    tick();

    // Single raw last block of 5 bytes.
    pulse_start();
    exp_hdr(1'b1, 2'd0, 21'd5);
    exp_byte(8'hA1, 1'b0); exp_byte(8'hA2, 1'b0); exp_byte(8'hA3, 1'b0);
    exp_byte(8'hA4, 1'b0); exp_byte(8'hA5, 1'b0);
    send(16'h0029, 2'b11);
    send(16'hA100, 2'b11);
    send(16'hA3A2, 2'b11);
    send(16'hA5A4, 2'b11);
    wait_flag("raw_finished", 0, 100);
    drained("raw");

    // RLE block: 0x7E four times.
    pulse_start();
    check("start_clears_finished", 32'(finished), 32'd0);
    exp_hdr(1'b1, 2'd1, 21'd4);
    for (int i = 0; i < 4; i++) exp_byte(8'h7E, 1'b1);
    send(16'h0023, 2'b11);
    send(16'h7E00, 2'b11);
    wait_flag("rle_finished", 0, 100);
    drained("rle");

    // Odd alignment, a discarded keep=00 word, random back-pressure.
    ready_mode = 1;
    pulse_start();
    exp_hdr(1'b1, 2'd0, 21'd5);
    exp_byte(8'hB1, 1'b0); exp_byte(8'hB2, 1'b0); exp_byte(8'hB3, 1'b0);
    exp_byte(8'hB4, 1'b0); exp_byte(8'hB5, 1'b0);
    send(16'hEE29, 2'b01);
    send(16'h0000, 2'b11);
    send(16'hFFFF, 2'b00);
    send(16'hB2B1, 2'b11);
    send(16'hB4B3, 2'b11);
    send(16'h00B5, 2'b01);
    wait_flag("bp_finished", 0, 400);
    drained("bp");
    ready_mode = 0;

    // Two blocks: raw size 1 then raw last size 0.
    pulse_start();
    exp_hdr(1'b0, 2'd0, 21'd1);
    exp_byte(8'h55, 1'b0);
    exp_hdr(1'b1, 2'd0, 21'd0);
    send(16'h0008, 2'b11);
    send(16'h5500, 2'b11);
    send(16'h0001, 2'b11);
    send(16'h0000, 2'b01);
    wait_flag("two_finished", 0, 100);
    drained("two");

    // Reserved block type.
    pulse_start();
    exp_hdr(1'b1, 2'd3, 21'd0);
    send(16'h0007, 2'b11);
    send(16'h0000, 2'b01);
    wait_flag("reserved_error", 1, 50);
    repeat (3) tick();
    @(negedge clk);
    check("error_sticky", 32'(error), 32'd1);
    check("error_in_ready", 32'(in_ready), 32'd0);
    check("error_finished", 32'(finished), 32'd0);
    tick();
    drained("reserved");

    // Oversize block: 131073 bytes.
    pulse_start();
    check("start_clears_error", 32'(error), 32'd0);
    exp_hdr(1'b0, 2'd0, 21'd131073);
    send(16'h0008, 2'b11);
    send(16'h0010, 2'b01);
    wait_flag("oversize_error", 1, 50);
    drained("oversize");

    // Reset in the middle of RLE emission, then a clean decode.
    ready_mode = 2;
    pulse_start();
    exp_hdr(1'b1, 2'd1, 21'd4);
    for (int i = 0; i < 4; i++) exp_byte(8'h7E, 1'b1);
    send(16'h0023, 2'b11);
    send(16'h7E00, 2'b11);
    wait_flag("emit_reached", 2, 50);
    check("emit_is_rle", 32'(out_is_rle), 32'd1);
    reset = 1'b1;
    tick();
    @(negedge clk);
    check_idle_outputs("midreset");
    oq.delete();
    tick();
    reset = 1'b0;
    ready_mode = 0;
    tick();
    pulse_start();
    exp_hdr(1'b1, 2'd0, 21'd2);
    exp_byte(8'hC1, 1'b0); exp_byte(8'hC2, 1'b0);
    send(16'h0011, 2'b11);
    send(16'hC100, 2'b11);
    send(16'h00C2, 2'b01);
    wait_flag("post_reset_finished", 0, 100);
    drained("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
